jpu_exec_ctrl: RTL
==================

// Module: jpu_exec_ctrl
// PURPOSE
//  Single-issue execute/control stage for the JPU, directly upstream of the 16x8 register file (reg16_8).
//  Accepts 16-bit instructions over a valid/ready handshake and sequences register-file reads and write-back.
//  Sequences each instruction read -> execute -> write-back, driving regfile enables, addresses and write data.
//  Computes results with an internal 16-bit ALU. Reports flags, retire pulses and a retired-instruction count.
// PARAMETERS
//  DATA_W   16  datapath/register width
//  ADDR_W   3   register address width (8 registers)
//  CNT_W    16  retired-instruction counter width
// PORTS
//  clock         in   1       rising-edge clock
//  reset         in   1       synchronous, active-high reset
//  I_instr       in   16      instruction: [15:12]op [11:9]rd [8:6]ra [5:3]rb [7:0]imm8
//  I_instr_valid in   1       instruction present
//  O_instr_ready out  1       stage can accept (IDLE only)
//  O_reg_en      out  1       regfile enable (high in READ and WRITE)
//  O_reg_wr_en   out  1       regfile write enable
//  O_reg_rd_en   out  1       regfile read enable
//  O_addrA       out  ADDR_W  regfile port A address (read ra / write rd)
//  O_addrB       out  ADDR_W  regfile port B address (rb)
//  O_wdata       out  DATA_W  regfile write data
//  I_dataA       in   DATA_W  regfile read data A
//  I_dataB       in   DATA_W  regfile read data B
//  O_flags       out  2       {carry, zero}
//  O_retire      out  1       one-cycle pulse per retired instruction
//  O_illegal     out  1       one-cycle pulse on undefined opcode
//  O_halted      out  1       HALT executed
//  O_retired     out  CNT_W   retired count, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (ready=0 during reset, 1 from first cycle after); flags=0; count=0.
//  Accept = I_instr_valid & O_instr_ready at clock edge; instruction latched; ready drops next cycle.
//  Opcodes: 0 NOP, 1 ADD, 2 SUB(A-B), 3 AND, 4 OR, 5 XOR, 6 NOT A, 7 SHL A by 1, 8 SHR A by 1 (logical),
//   9 LDI rd<={8'h00,imm8}, F HALT, A-E illegal.
//  FSM: IDLE -> READ -> EXEC -> WRITE -> IDLE for ALU ops (1-8); 4 cycles/instr.
//   IDLE -> WRITE -> IDLE for LDI.
//   NOP: stays IDLE, O_retire next cycle. Illegal: stays IDLE, O_illegal next cycle, no retire/count.
//   HALT: -> HALT state, O_retire next cycle, O_halted=1, ready=0 until reset.
//  READ: reg_en=rd_en=1, addrA=ra, addrB=rb. Regfile data valid in following cycle.
//  EXEC: sample I_dataA/I_dataB, compute; result and flags registered at end of EXEC; no enables.
//  WRITE: reg_en=wr_en=1, addrA=rd, O_wdata=result, O_retire=1, count+1.
//  addrA/addrB/wdata hold last values outside READ/WRITE; enables strictly 0 outside their states.
//  Flags: zero=(result==0). carry = ADD carry-out, SUB borrow (A<B unsigned), SHL bit15 out,
//   SHR bit0 out, 0 for logic ops and LDI. NOP/illegal/HALT leave flags unchanged.
//  Arithmetic is DATA_W-bit modular: 16'hFFFF+1 -> 0, carry=1.
//  I_instr changes while not accepted are ignored; valid held across busy cycles is accepted in next IDLE.
//  Reset mid-instruction: abort; no write issued in or after the reset cycle; flags/count cleared.
// TESTING
//  LDI r1,0x31; LDI r3,0x43 -> WRITE cycles addrA=1 wdata=0x0031, addrA=3 wdata=0x0043; retired=2.
//  ADD r2,r1,r3 (regfile model) -> READ addrA=1 addrB=3; 3 cycles later wr addrA=2 wdata=0x0074, flags=00.
//  SUB r4,r1,r3 (0x31-0x43) -> wdata=0xFFEE, carry=1, zero=0; ADD 0xFFFF+0x0001 -> 0x0000, flags=11.
//  Valid held high through back-to-back ADDs -> ready only in IDLE, one accept per 4 cycles, no drops.
//  Opcode 0xA -> O_illegal pulse, retired unchanged; HALT -> O_halted=1, ready stays 0 with valid high.
//  reset asserted during EXEC of ADD -> no wr_en pulse; next cycle IDLE, ready=1, flags=00, retired=0.

Source files
------------

// File: rtl/jpu_exec_ctrl.sv
// JPU execute/control stage.
// Takes one 16-bit instruction at a time over a valid/ready handshake, drives
// the 16x8 register file through read, execute and write-back, and reports
// flags, retire/illegal pulses and a running retired-instruction count.
module jpu_exec_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       I_instr,
  input  logic              I_instr_valid,
  output logic              O_instr_ready,
  output logic              O_reg_en,
  output logic              O_reg_wr_en,
  output logic              O_reg_rd_en,
  output logic [ADDR_W-1:0] O_addrA,
  output logic [ADDR_W-1:0] O_addrB,
  output logic [DATA_W-1:0] O_wdata,
  input  logic [DATA_W-1:0] I_dataA,
  input  logic [DATA_W-1:0] I_dataB,
  output logic [1:0]        O_flags,
  output logic              O_retire,
  output logic              O_illegal,
  output logic              O_halted,
  output logic [CNT_W-1:0]  O_retired
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE,
    ST_HALT
  } state_t;

  state_t state;

  logic              ready_q;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] rd_q;

  logic [3:0]        in_op;
  logic [ADDR_W-1:0] in_rd;
  logic [ADDR_W-1:0] in_ra;
  logic [ADDR_W-1:0] in_rb;
  logic [7:0]        in_imm;

  logic [DATA_W:0]   alu_wide;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  assign in_op  = I_instr[15:12];
  assign in_rd  = I_instr[11:9];
  assign in_ra  = I_instr[8:6];
  assign in_rb  = I_instr[5:3];
  assign in_imm = I_instr[7:0];

  // Ready is held low for as long as reset is asserted, even though the
  // registered idle flag is already set by the reset edge.
  assign O_instr_ready = ready_q && !reset;

  // ALU: result and carry for the latched opcode from the regfile read data.
  always_comb begin
    alu_wide  = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_wide  = {1'b0, I_dataA} + {1'b0, I_dataB};
        alu_res   = alu_wide[DATA_W-1:0];
        alu_carry = alu_wide[DATA_W];
      end
      OP_SUB: begin
        alu_res   = I_dataA - I_dataB;
        alu_carry = (I_dataA < I_dataB);
      end
      OP_AND: alu_res = I_dataA & I_dataB;
      OP_OR:  alu_res = I_dataA | I_dataB;
      OP_XOR: alu_res = I_dataA ^ I_dataB;
      OP_NOT: alu_res = ~I_dataA;
      OP_SHL: begin
        alu_res   = {I_dataA[DATA_W-2:0], 1'b0};
        alu_carry = I_dataA[DATA_W-1];
      end
      OP_SHR: begin
        alu_res   = {1'b0, I_dataA[DATA_W-1:1]};
        alu_carry = I_dataA[0];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // Sequencer: accepts instructions in IDLE and walks them through the
  // regfile read, execute and write-back cycles with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b1;
      op_q        <= '0;
      rd_q        <= '0;
      O_reg_en    <= 1'b0;
      O_reg_wr_en <= 1'b0;
      O_reg_rd_en <= 1'b0;
      O_addrA     <= '0;
      O_addrB     <= '0;
      O_wdata     <= '0;
      O_flags     <= 2'b00;
      O_retire    <= 1'b0;
      O_illegal   <= 1'b0;
      O_halted    <= 1'b0;
      O_retired   <= '0;
    end else begin
      O_reg_en    <= 1'b0;
      O_reg_wr_en <= 1'b0;
      O_reg_rd_en <= 1'b0;
      O_retire    <= 1'b0;
      O_illegal   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (I_instr_valid && ready_q) begin
            op_q <= in_op;
            rd_q <= in_rd;
            case (in_op)
              OP_NOP: begin
                O_retire  <= 1'b1;
                O_retired <= O_retired + CNT_ONE;
              end
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
                state       <= ST_READ;
                ready_q     <= 1'b0;
                O_reg_en    <= 1'b1;
                O_reg_rd_en <= 1'b1;
                O_addrA     <= in_ra;
                O_addrB     <= in_rb;
              end
              OP_LDI: begin
                state       <= ST_WRITE;
                ready_q     <= 1'b0;
                O_reg_en    <= 1'b1;
                O_reg_wr_en <= 1'b1;
                O_addrA     <= in_rd;
                O_wdata     <= {{(DATA_W-8){1'b0}}, in_imm};
                O_flags     <= {1'b0, (in_imm == 8'h00)};
                O_retire    <= 1'b1;
                O_retired   <= O_retired + CNT_ONE;
              end
              OP_HALT: begin
                state     <= ST_HALT;
                ready_q   <= 1'b0;
                O_retire  <= 1'b1;
                O_retired <= O_retired + CNT_ONE;
                O_halted  <= 1'b1;
              end
              default: begin
                O_illegal <= 1'b1;
              end
            endcase
          end
        end
        ST_READ: begin
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          state       <= ST_WRITE;
          O_reg_en    <= 1'b1;
          O_reg_wr_en <= 1'b1;
          O_addrA     <= rd_q;
          O_wdata     <= alu_res;
          O_flags     <= {alu_carry, (alu_res == '0)};
          O_retire    <= 1'b1;
          O_retired   <= O_retired + CNT_ONE;
        end
        ST_WRITE: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
